// File: rtl/decode_stage_pipelined.sv
// Pipelined MIPS decode stage: register file with optional write-back bypass,
// RegDst select, load-use hazard detection and the ID/EX pipeline register.
module decode_stage_pipelined #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit BYPASS_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_Rs,
  input  logic [ADDR_W-1:0] i_Rt,
  input  logic [ADDR_W-1:0] i_Rd,
  input  logic              i_c_regDst,
  input  logic              i_c_regWrite,
  input  logic              i_c_memRead,
  input  logic              i_hold,
  input  logic              i_flush,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic              o_stall,
  output logic              o_ex_valid,
  output logic [DATA_W-1:0] o_ex_op1,
  output logic [DATA_W-1:0] o_ex_op2,
  output logic [ADDR_W-1:0] o_ex_wrAddr,
  output logic              o_ex_regWrite,
  output logic              o_ex_memRead
);

  localparam int NUM_REGS = 2**ADDR_W;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [ADDR_W-1:0] wr_addr;
    logic              reg_write;
    logic              mem_read;
  } id_ex_t;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wb_write;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [ADDR_W-1:0] dest;
  id_ex_t            ex_q;
  id_ex_t            ex_d;

  assign wb_write = i_wb_we && (i_wb_addr != '0);

  // NOTE: the register file is cleared on reset because software may read any
  // register before writing it; a reset array cannot map onto a plain RAM macro.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs <= '{default: '0};
    end else if (wb_write) begin
      regs[i_wb_addr] <= i_wb_data;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which is what would otherwise infer a latch.
  always_comb begin
    rs_data = regs[i_Rs];
    rt_data = regs[i_Rt];
    if (BYPASS_EN && wb_write && (i_wb_addr == i_Rs)) rs_data = i_wb_data;
    if (BYPASS_EN && wb_write && (i_wb_addr == i_Rt)) rt_data = i_wb_data;
    if (i_Rs == '0) rs_data = '0;
    if (i_Rt == '0) rt_data = '0;
  end

  assign dest = i_c_regDst ? i_Rd : i_Rt;

  // A load still in ID/EX cannot feed an instruction reading its destination.
  assign o_stall = i_valid && ex_q.valid && ex_q.mem_read && (ex_q.wr_addr != '0) &&
                   ((ex_q.wr_addr == i_Rs) || (ex_q.wr_addr == i_Rt));

  always_comb begin
    ex_d = ex_q;
    if (i_flush) begin
      ex_d = '0;
    end else if (i_hold) begin
      ex_d = ex_q;
    end else if (o_stall) begin
      ex_d = '0;
    end else begin
      ex_d.valid     = i_valid;
      ex_d.op1       = rs_data;
      ex_d.op2       = rt_data;
      ex_d.wr_addr   = dest;
      ex_d.reg_write = i_c_regWrite && i_valid;
      ex_d.mem_read  = i_c_memRead && i_valid;
    end
  end

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign o_ex_valid    = ex_q.valid;
  assign o_ex_op1      = ex_q.op1;
  assign o_ex_op2      = ex_q.op2;
  assign o_ex_wrAddr   = ex_q.wr_addr;
  assign o_ex_regWrite = ex_q.reg_write;
  assign o_ex_memRead  = ex_q.mem_read;

endmodule
